// File: rtl/code_entry_if.sv
// Keypad-entry bus between the lock FSM and the code_entry block.
// master: the FSM side (drives buttons and control strobes).
// slave:  the code_entry block (returns entry status and match).
interface code_entry_if;
    logic [3:0] btn;
    logic       capture_en;
    logic       clear;
    logic       verify;
    logic       match;
    logic [3:0] digit_count;
    logic       full;
    logic       invalid;
    logic       bad_seq;
    logic       lockout;

    modport master (
        output btn,
        output capture_en,
        output clear,
        output verify,
        input  match,
        input  digit_count,
        input  full,
        input  invalid,
        input  bad_seq,
        input  lockout
    );

    modport slave (
        input  btn,
        input  capture_en,
        input  clear,
        input  verify,
        output match,
        output digit_count,
        output full,
        output invalid,
        output bad_seq,
        output lockout
    );
endinterface

// File: rtl/code_entry.sv
// code_entry: keypad input stage for the lock FSM.
// Edge-detects one-hot keypad presses, rejects multi-button presses, buffers
// up to CODE_LEN 2-bit digits and reports a combinational match against PASSWORD.
// Optional feature: define LOCKOUT_EN to build the consecutive-failure counter
// that locks the keypad after MAX_FAILS failed verifications.
module code_entry #(
    parameter int unsigned               CODE_LEN  = 4,      // 1..8 digits
    parameter logic [2*CODE_LEN-1:0]     PASSWORD  = 8'h72,  // digit 0 in bits [1:0]
    parameter int unsigned               MAX_FAILS = 3
) (
    input logic          clk,
    input logic          reset,
    code_entry_if.slave  bus
);

    localparam logic [3:0] CodeLen = 4'(CODE_LEN);

    // Registered state
    logic [3:0]            btn_q;
    logic [2*CODE_LEN-1:0] buffer_q, buffer_d;
    logic [3:0]            count_q, count_d;
    logic                  bad_q, bad_d;
    logic                  invalid_q, invalid_d;

    // Press decode
    logic       press_evt;
    logic       single;
    logic [1:0] digit;
    logic       accept;
    logic       lockout;
    logic       is_full;
    logic       match_raw;

    // Press detection and digit decode
    always_comb begin
        press_evt = (bus.btn != 4'd0) && (btn_q == 4'd0);
        // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero
        single    = (bus.btn != 4'd0) && ((bus.btn & (bus.btn - 4'd1)) == 4'd0);
        case (bus.btn)
            4'b0001: digit = 2'd0;
            4'b0010: digit = 2'd1;
            4'b0100: digit = 2'd2;
            4'b1000: digit = 2'd3;
            default: digit = 2'd0;
        endcase
        // clear wins over a press in the same cycle; lockout freezes the keypad
        accept = press_evt && bus.capture_en && !lockout && !bus.clear;
    end

    // Next-state for the entry buffer, digit count and error flags
    always_comb begin
        buffer_d  = buffer_q;
        count_d   = count_q;
        bad_d     = bad_q;
        invalid_d = 1'b0;
        if (bus.clear) begin
            buffer_d = '0;
            count_d  = 4'd0;
            bad_d    = 1'b0;
        end else if (accept) begin
            if (single) begin
                if (count_q < CodeLen) begin
                    for (int i = 0; i < CODE_LEN; i++) begin
                        if (count_q == 4'(i)) begin
                            buffer_d[2*i +: 2] = digit;
                        end
                    end
                    count_d = count_q + 4'd1;
                end else begin
                    // Overflow: extra digit poisons the sequence
                    bad_d = 1'b1;
                end
            end else begin
                invalid_d = 1'b1;
                bad_d     = 1'b1;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q     <= 4'd0;
            buffer_q  <= '0;
            count_q   <= 4'd0;
            bad_q     <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            btn_q     <= bus.btn;
            buffer_q  <= buffer_d;
            count_q   <= count_d;
            bad_q     <= bad_d;
            invalid_q <= invalid_d;
        end
    end

    // Status outputs are pure functions of registered state
    always_comb begin
        is_full   = (count_q == CodeLen);
        match_raw = is_full && !bad_q && (buffer_q == PASSWORD);
    end

`ifdef LOCKOUT_EN
    localparam int unsigned        FailW    = $clog2(MAX_FAILS + 1);
    localparam logic [FailW-1:0]   MaxFails = FailW'(MAX_FAILS);

    logic [FailW-1:0] fail_q, fail_d;

    // Saturating count of consecutive failed verifications
    always_comb begin
        fail_d = fail_q;
        if (bus.verify) begin
            if (match_raw && !lockout) begin
                fail_d = '0;
            end else if (fail_q != MaxFails) begin
                fail_d = fail_q + FailW'(1);
            end
        end
    end

    // Fail counter register; only reset clears it, not clear
    always_ff @(posedge clk) begin
        if (reset) begin
            fail_q <= '0;
        end else begin
            fail_q <= fail_d;
        end
    end

    assign lockout = (fail_q == MaxFails);
`else
    logic unused_verify;

    // No failure tracking in this build
    assign lockout       = 1'b0;
    assign unused_verify = bus.verify ^ (MAX_FAILS != 0);
`endif

    assign bus.match       = match_raw && !lockout;
    assign bus.digit_count = count_q;
    assign bus.full        = is_full;
    assign bus.invalid     = invalid_q;
    assign bus.bad_seq     = bad_q;
    assign bus.lockout     = lockout;

endmodule

// File: doc/code_entry.md
Name: code_entry

Overview:
- Upstream input stage for the keypad lock FSM.
- Decodes the one-hot 4-button keypad, edge-detects presses and rejects multi-button presses.
- Buffers the entered digit sequence while the FSM is in INPUT, and produces the match signal the FSM consumes in VERIFY.
- Instantiated beside the FSM: the FSM drives capture_en, clear and verify, and this block returns match.

Parameters:
- CODE_LEN, 4: number of digits in a code; legal range 1..8.
- PASSWORD, 8'h72: packed code, 2 bits per digit. Digit i is PASSWORD[2i+1:2i], digit 0 is entered first. Width is 2*CODE_LEN. Default code is 2,0,3,1.
- MAX_FAILS, 3: consecutive failed verifications before lockout. Used only with LOCKOUT_EN.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- btn  input  4  raw keypad buttons, one-hot when valid; btn[k] means digit k.
- capture_en  input  1  high while the FSM is in INPUT; presses are recorded only when high.
- clear  input  1  flush the entry buffer.
- verify  input  1  one-cycle strobe, asserted by the FSM while in VERIFY.
- match  output  1  complete, clean sequence equals PASSWORD.
- digit_count  output  4  number of digits stored, 0..CODE_LEN.
- full  output  1  digit_count == CODE_LEN.
- invalid  output  1  one-cycle pulse on a rejected press.
- bad_seq  output  1  sticky: sequence was corrupted by an invalid press or overflow.
- lockout  output  1  too many failures; capture disabled.

Behaviour:
- Reset (clk edge with reset=1): btn_q=0, buffer=0, digit_count=0, bad_seq=0, invalid=0, fail counter=0. Resulting outputs: match=0, full=0, lockout=0.
- Edge detect:
  - btn_q registers btn every cycle, regardless of capture_en.
  - A press event in cycle t is btn!=0 && btn_q==0.
  - Holding buttons produces no further events. Changing from one nonzero pattern to another without releasing produces no event.
- Valid press: press event with exactly one bit set. Digit = index of the set bit (0..3).
- Invalid press: press event with 2+ bits set.
- Both press kinds are acted on only when capture_en=1 and lockout=0. Otherwise they are ignored and invalid stays 0.
- Accepted valid press, digit_count<CODE_LEN:
  - buffer[digit_count] <= digit.
  - digit_count increments at the next edge.
- Accepted valid press, digit_count==CODE_LEN (overflow): nothing stored, count holds, bad_seq<=1.
- Accepted invalid press: nothing stored, count holds, invalid=1 for exactly one cycle, bad_seq<=1.
- clear=1:
  - At the next edge: digit_count=0, buffer=0, bad_seq=0.
  - Has priority over a press in the same cycle; that press is discarded and invalid stays 0.
  - Does not affect btn_q.
- match is combinational from registers: (digit_count==CODE_LEN) && !bad_seq && (buffer==PASSWORD).
  - A press at edge t is reflected on match after edge t.
  - Zero added latency, so match is stable when the FSM reaches VERIFY.
- full is combinational from digit_count.
- verify has no effect on the buffer; the FSM must pulse clear to start a new entry.
- Reset mid-entry discards everything. No partial state survives.

Optional Feature:
- Macro: LOCKOUT_EN.
- Defined:
  - Saturating fail counter, width $clog2(MAX_FAILS+1).
  - verify && !match increments the counter at the next edge.
  - verify && match zeroes it.
  - lockout = (counter==MAX_FAILS).
  - While lockout=1, all presses are ignored and match is forced to 0.
  - clear does NOT reset the counter; only reset does.
- Undefined: no counter is built, lockout is tied to 0, and verify is unused.

Test Plan:
- Reset, then capture_en=1; press btn=4'b0100, 0001, 1000, 0010 with one idle cycle between each -> digit_count steps 1,2,3,4; full=1; match=1; bad_seq=0.
- Same sequence, but hold btn=4'b0100 for 5 cycles -> digit_count=1 after the hold, not 5.
- Press btn=4'b0110 mid-sequence -> invalid=1 for exactly one cycle, digit_count unchanged, bad_seq=1, match=0 after four valid digits; clear then re-entry of 2,0,3,1 -> match=1.
- Five valid presses 2,0,3,1,0 -> count stays 4, bad_seq=1, match=0. Press together with clear in the same cycle -> digit_count=0, invalid=0.
- capture_en=0 with presses -> digit_count stays 0. Reset asserted after 2 digits -> digit_count=0, match=0 the next cycle.
- LOCKOUT_EN defined, MAX_FAILS=3: three verify pulses with wrong code 0,0,0,0 -> lockout=1 after the third, further presses ignored, clear keeps lockout=1, reset clears it. Macro undefined -> lockout stays 0 in the same stimulus.
